// File: rtl/iter_counter.sv
// ----------------------------------------------------------------------------
// iter_counter
//
// Loadable up/down iteration counter used to sequence iteration indices
// (CORDIC stage number, angle-table address) in the sine/cosine datapath.
// A start pulse latches the first/last values, the direction and the mode.
// The counter then walks from init toward limit one step per enabled cycle.
// A one-shot run ends with a done pulse. A periodic run reloads init and
// emits a wrap pulse each time it passes limit.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       single-cycle request: latch init/limit/dir/mode, begin a run
//   abort       end the current run without done
//   enable      advance qualifier; count moves only when high
//   dir         0 = count down, 1 = count up (sampled on start)
//   mode        0 = one-shot, 1 = periodic auto-reload (sampled on start)
//   init        first count value (sampled on start)
//   limit       last count value (sampled on start)
//   q           current count (registered)
//   busy        high while a run is active (registered)
//   first_tick  busy & (q == latched init), combinational
//   last_tick   busy & (q == latched limit), combinational
//   done        one-cycle pulse when a one-shot run completes (registered)
//   wrap        one-cycle pulse when a periodic run reloads (registered)
// ----------------------------------------------------------------------------
module iter_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         enable,
    input  logic         dir,
    input  logic         mode,
    input  logic [W-1:0] init,
    input  logic [W-1:0] limit,
    output logic [W-1:0] q,
    output logic         busy,
    output logic         first_tick,
    output logic         last_tick,
    output logic         done,
    output logic         wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   init_r_q, init_r_d;
    logic [W-1:0]   limit_r_q, limit_r_d;
    logic           dir_r_q, dir_r_d;
    logic           mode_r_q, mode_r_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           wrap_q, wrap_d;

    logic           at_limit;

    assign at_limit = (q_q == limit_r_q);

    // Next-state logic. Priority inside RUN is abort > start > enable.
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        init_r_d  = init_r_q;
        limit_r_d = limit_r_q;
        dir_r_d   = dir_r_q;
        mode_r_d  = mode_r_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort in IDLE is a no-op; enable is ignored in the start cycle.
                if (start) begin
                    init_r_d  = init;
                    limit_r_d = limit;
                    dir_r_d   = dir;
                    mode_r_d  = mode;
                    q_d       = init;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // q holds its value so the aborted position stays visible.
                    state_d = IDLE;
                end else if (start) begin
                    // Restart: a pending last_tick & enable is discarded, no pulse.
                    init_r_d  = init;
                    limit_r_d = limit;
                    dir_r_d   = dir;
                    mode_r_d  = mode;
                    q_d       = init;
                end else if (enable) begin
                    if (at_limit) begin
                        if (mode_r_q) begin
                            q_d    = init_r_q;
                            wrap_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (dir_r_q) begin
                        // Modulo-2^W arithmetic: wrong-direction runs wrap through 0.
                        q_d = q_q + 1'b1;
                    end else begin
                        q_d = q_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            q_q       <= '0;
            init_r_q  <= '0;
            limit_r_q <= '0;
            dir_r_q   <= 1'b0;
            mode_r_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            init_r_q  <= init_r_d;
            limit_r_q <= limit_r_d;
            dir_r_q   <= dir_r_d;
            mode_r_q  <= mode_r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    assign q          = q_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wrap       = wrap_q;
    assign first_tick = busy_q & (q_q == init_r_q);
    assign last_tick  = busy_q & at_limit;

endmodule

// File: tb/tb_iter_counter.sv
module tb_iter_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, enable, dir, mode;
    logic [4:0] init5, limit5, q5;
    logic [3:0] init4, limit4, q4;
    logic       busy5, ft5, lt5, done5, wrap5;
    logic       busy4, ft4, lt4, done4, wrap4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iter_counter #(.W(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .enable(enable),
        .dir(dir), .mode(mode), .init(init5), .limit(limit5), .q(q5),
        .busy(busy5), .first_tick(ft5), .last_tick(lt5), .done(done5), .wrap(wrap5)
    );

    iter_counter #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .enable(enable),
        .dir(dir), .mode(mode), .init(init4), .limit(limit4), .q(q4),
        .busy(busy4), .first_tick(ft4), .last_tick(lt4), .done(done4), .wrap(wrap4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned pq [5];
        int unsigned pw [5];
        pq = '{4, 5, 6, 3, 4};
        pw = '{0, 0, 0, 1, 0};

        rst = 1'b0; start = 0; abort = 0; enable = 0; dir = 0; mode = 0;
        init5 = '0; limit5 = '0; init4 = '0; limit4 = '0;
        #12;
        chk("rst_q", q5, 0);
        chk("rst_busy", busy5, 0);
        chk("rst_done", done5, 0);
        chk("rst_wrap", wrap5, 0);
        rst = 1'b1;
        enable = 1;
        step();
        chk("idle_busy", busy5, 0);
        chk("idle_ft", ft5, 0);

        // One-shot down 10 -> 0
        init5 = 10; limit5 = 0; dir = 0; mode = 0; start = 1; enable = 1;
        step();
        start = 0;
        chk("dn_q0", q5, 10);
        chk("dn_busy0", busy5, 1);
        chk("dn_ft0", ft5, 1);
        chk("dn_lt0", lt5, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("dn_q", q5, 10 - i);
            chk("dn_done_early", done5, 0);
        end
        chk("dn_lt_end", lt5, 1);
        chk("dn_ft_end", ft5, 0);
        step();
        chk("dn_done", done5, 1);
        chk("dn_busy_end", busy5, 0);
        chk("dn_q_hold", q5, 0);
        chk("dn_lt_idle", lt5, 0);
        step();
        chk("dn_done_clr", done5, 0);
        chk("dn_q_hold2", q5, 0);

        // Periodic up 3..6 with enable gaps
        init5 = 3; limit5 = 6; dir = 1; mode = 1; start = 1; enable = 0;
        step();
        start = 0;
        chk("per_q0", q5, 3);
        for (int i = 0; i < 5; i++) begin
            enable = 1;
            step();
            chk("per_q", q5, pq[i]);
            chk("per_wrap", wrap5, pw[i]);
            chk("per_busy", busy5, 1);
            chk("per_done", done5, 0);
            enable = 0;
            step();
            chk("per_q_gap", q5, pq[i]);
            chk("per_wrap_gap", wrap5, 0);
        end

        // Reset mid-run at q=9
        init5 = 9; limit5 = 20; dir = 1; mode = 1; start = 1;
        step();
        start = 0;
        chk("mr_q9", q5, 9);
        rst = 1'b0;
        #1;
        chk("mr_q", q5, 0);
        chk("mr_busy", busy5, 0);
        chk("mr_done", done5, 0);
        chk("mr_wrap", wrap5, 0);
        #1;
        rst = 1'b1;
        enable = 1;
        step();
        step();
        chk("mr_idle_busy", busy5, 0);
        chk("mr_idle_q", q5, 0);

        // W=4 wrap-around up: 14,15,0,1 then done
        init4 = 14; limit4 = 1; dir = 1; mode = 0; start = 1; enable = 1;
        step();
        start = 0;
        chk("wu_q0", q4, 14);
        step(); chk("wu_q1", q4, 15);
        step(); chk("wu_q2", q4, 0);
        step(); chk("wu_q3", q4, 1);
        chk("wu_lt", lt4, 1);
        chk("wu_done_early", done4, 0);
        step();
        chk("wu_done", done4, 1);
        chk("wu_busy", busy4, 0);
        chk("wu_q_hold", q4, 1);

        // W=4 down 14 -> 1 over 14 enabled cycles
        dir = 0; start = 1;
        step();
        start = 0;
        chk("wd_q0", q4, 14);
        for (int i = 1; i <= 13; i++) begin
            step();
            chk("wd_q", q4, 14 - i);
            chk("wd_done_early", done4, 0);
        end
        step();
        chk("wd_done", done4, 1);
        chk("wd_q_hold", q4, 1);

        // Restart at last_tick, then abort+start+enable
        init5 = 2; limit5 = 4; dir = 1; mode = 0; start = 1; enable = 1;
        step();
        start = 0;
        step(); chk("rs_q3", q5, 3);
        step(); chk("rs_q4", q5, 4);
        chk("rs_lt", lt5, 1);
        init5 = 7; start = 1;
        step();
        start = 0;
        chk("rs_q7", q5, 7);
        chk("rs_no_done", done5, 0);
        chk("rs_busy", busy5, 1);
        step(); chk("rs_q8", q5, 8);
        abort = 1; start = 1; init5 = 1;
        step();
        abort = 0; start = 0;
        chk("ab_busy", busy5, 0);
        chk("ab_q", q5, 8);
        chk("ab_done", done5, 0);
        step();
        chk("ab_q_hold", q5, 8);
        chk("ab_done2", done5, 0);
        chk("ab_ft", ft5, 0);

        // Degenerate init == limit == 5
        init5 = 5; limit5 = 5; dir = 1; mode = 0; start = 1; enable = 0;
        step();
        start = 0;
        chk("dg_ft", ft5, 1);
        chk("dg_lt", lt5, 1);
        enable = 1;
        step();
        chk("dg_done", done5, 1);
        chk("dg_busy", busy5, 0);
        chk("dg_q", q5, 5);
        // Back-to-back start while done is high, periodic this time
        mode = 1; start = 1; enable = 1;
        step();
        start = 0;
        chk("dp_busy", busy5, 1);
        chk("dp_done_clr", done5, 0);
        chk("dp_wrap0", wrap5, 0);
        step();
        chk("dp_wrap1", wrap5, 1);
        chk("dp_q1", q5, 5);
        step();
        chk("dp_wrap2", wrap5, 1);
        chk("dp_busy2", busy5, 1);
        enable = 0;
        step();
        chk("dp_wrap_off", wrap5, 0);
        chk("dp_q_end", q5, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
